// File: rtl/point_dispatcher.sv
// Raster-order frame driver for one Mandelbrot point generator: issues a start per pixel, captures the iteration count, writes it out.
// Latency: 3 cycles per pixel (START, WAIT, WRITE) with immediate generator ready and ack; pixels are not overlapped.
// Backpressure: waits indefinitely on pg_ready and on pix_ack, holding the pixel write stable; abort cancels at any point.
module point_dispatcher #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int HBI    = 32
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           frame_start,
    input  logic           abort,
    output logic           busy,
    output logic           frame_done,
    output logic           pg_start,
    output logic [11:0]    pg_x,
    output logic [11:0]    pg_y,
    input  logic           pg_ready,
    input  logic [HBI-1:0] pg_iteration,
    output logic           pix_valid,
    output logic [11:0]    pix_x,
    output logic [11:0]    pix_y,
    output logic [HBI-1:0] pix_data,
    input  logic           pix_ack
);

    localparam logic [11:0] X_LAST = 12'(WIDTH - 1);
    localparam logic [11:0] Y_LAST = 12'(HEIGHT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_WAIT  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [11:0]      r_x;
    logic [11:0]      r_y;
    logic [11:0]      w_x_next;
    logic [11:0]      w_y_next;
    logic             w_capture;

    logic             r_busy;
    logic             r_frame_done;
    logic             r_pg_start;
    logic             r_pix_valid;
    logic [11:0]      r_pix_x;
    logic [11:0]      r_pix_y;
    logic [HBI-1:0]   r_pix_data;

    // Next-state, counter advance and capture decision; abort overrides everything outside IDLE.
    always_comb begin
        w_next    = r_state;
        w_x_next  = r_x;
        w_y_next  = r_y;
        w_capture = 1'b0;
        unique case (r_state)
            // DONE already counts as idle for a new request so a back-to-back frame is not lost.
            S_IDLE, S_DONE: begin
                if (frame_start) begin
                    w_next   = S_START;
                    w_x_next = '0;
                    w_y_next = '0;
                end else begin
                    w_next = S_IDLE;
                end
            end
            // pg_ready is stale during START, so it is never looked at here.
            S_START: w_next = S_WAIT;
            S_WAIT: begin
                if (pg_ready) begin
                    w_next    = S_WRITE;
                    w_capture = 1'b1;
                end
            end
            S_WRITE: begin
                if (pix_ack) begin
                    if (r_x < X_LAST) begin
                        w_x_next = r_x + 12'd1;
                        w_next   = S_START;
                    end else if (r_y < Y_LAST) begin
                        w_x_next = '0;
                        w_y_next = r_y + 12'd1;
                        w_next   = S_START;
                    end else begin
                        w_next = S_DONE;
                    end
                end
            end
            default: w_next = S_IDLE;
        endcase
        if (abort && (r_state != S_IDLE)) begin
            w_next    = S_IDLE;
            w_x_next  = r_x;
            w_y_next  = r_y;
            w_capture = 1'b0;
        end
    end

    // State, counters and registered outputs, all derived from the next state so each output matches its state.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state      <= S_IDLE;
            r_x          <= '0;
            r_y          <= '0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_pg_start   <= 1'b0;
            r_pix_valid  <= 1'b0;
            r_pix_x      <= '0;
            r_pix_y      <= '0;
            r_pix_data   <= '0;
        end else begin
            r_state      <= w_next;
            r_x          <= w_x_next;
            r_y          <= w_y_next;
            r_busy       <= (w_next == S_START) || (w_next == S_WAIT) || (w_next == S_WRITE);
            r_frame_done <= (w_next == S_DONE);
            r_pg_start   <= (w_next == S_START);
            r_pix_valid  <= (w_next == S_WRITE);
            if (w_capture) begin
                r_pix_x    <= r_x;
                r_pix_y    <= r_y;
                r_pix_data <= pg_iteration;
            end
        end
    end

    assign busy       = r_busy;
    assign frame_done = r_frame_done;
    assign pg_start   = r_pg_start;
    assign pg_x       = r_x;
    assign pg_y       = r_y;
    assign pix_valid  = r_pix_valid;
    assign pix_x      = r_pix_x;
    assign pix_y      = r_pix_y;
    assign pix_data   = r_pix_data;

endmodule

// File: tb/tb_point_dispatcher.sv
// Bench for point_dispatcher: 4x2 grid instance driven by a generator/writer model, plus a 1x1 instance.
// Expected writes come from raster order; expected frame length is the sum of per-pixel START+WAIT+WRITE cycles.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_point_dispatcher;

    localparam int W    = 4;
    localparam int H    = 2;
    localparam int HB   = 32;
    localparam int NPIX = W * H;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    logic           frame_start, abort, busy, frame_done, pg_start, pg_ready, pix_valid, pix_ack;
    logic [11:0]    pg_x, pg_y, pix_x, pix_y;
    logic [HB-1:0]  pg_iteration, pix_data;

    logic           s_frame_start, s_abort, s_busy, s_frame_done, s_pg_start, s_pg_ready, s_pix_valid, s_pix_ack;
    logic [11:0]    s_pg_x, s_pg_y, s_pix_x, s_pix_y;
    logic [HB-1:0]  s_pg_iteration, s_pix_data;

    point_dispatcher #(.WIDTH(W), .HEIGHT(H), .HBI(HB)) dut (
        .CLK(CLK), .RST(RST), .frame_start(frame_start), .abort(abort), .busy(busy),
        .frame_done(frame_done), .pg_start(pg_start), .pg_x(pg_x), .pg_y(pg_y),
        .pg_ready(pg_ready), .pg_iteration(pg_iteration), .pix_valid(pix_valid),
        .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data), .pix_ack(pix_ack)
    );

    point_dispatcher #(.WIDTH(1), .HEIGHT(1), .HBI(HB)) dut1 (
        .CLK(CLK), .RST(RST), .frame_start(s_frame_start), .abort(s_abort), .busy(s_busy),
        .frame_done(s_frame_done), .pg_start(s_pg_start), .pg_x(s_pg_x), .pg_y(s_pg_y),
        .pg_ready(s_pg_ready), .pg_iteration(s_pg_iteration), .pix_valid(s_pix_valid),
        .pix_x(s_pix_x), .pix_y(s_pix_y), .pix_data(s_pix_data), .pix_ack(s_pix_ack)
    );

    logic [51:0] outs0;
    assign outs0 = {busy, frame_done, pg_start, pix_valid, pg_x, pg_y, pix_x, pix_y};

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Per-pixel generator/writer behaviour for the next frame (indexed by raster position).
    int            rd_arr [NPIX];   // ready appears in this WAIT cycle (1 = first)
    int            ad_arr [NPIX];   // ack appears in this WRITE cycle (1 = first)
    logic [HB-1:0] it_arr [NPIX];

    bit k_stale      = 0;
    int k_mid_fs     = -1;
    bit k_fs_at_done = 0;
    bit k_skip_start = 0;
    int k_abort_pix  = -1;
    int k_rst_pix    = -1;

    int r_len, r_starts, r_writes;
    bit r_done_seen;

    typedef struct {
        int rd;
        int ad;
        int exp_len;
        int exp_writes;
    } vec_t;

    task automatic fill(input int rd, input int ad);
        for (int k = 0; k < NPIX; k++) begin
            rd_arr[k] = rd;
            ad_arr[k] = ad;
            it_arr[k] = HB'((k % W) + 10 * (k / W));
        end
    endtask

    function automatic int model_len();
        int s = 0;
        for (int k = 0; k < NPIX; k++) s += 1 + rd_arr[k] + ad_arr[k];
        return s;
    endfunction

    // Runs one frame on the 4x2 instance, acting as generator and framebuffer writer.
    task automatic run_frame();
        int cyc = 0;
        int busy_cyc = -1;
        int start_idx = 0;
        int wr_idx = 0;
        int wcnt = 0;
        int acnt = 0;
        bit waiting = 0;
        bit ready_given = 0;
        bit writing = 0;
        bit finished = 0;
        logic [55:0] held = '0;
        r_starts = 0; r_writes = 0; r_len = -1; r_done_seen = 0;
        if (!k_skip_start) begin
            @(negedge CLK);
            frame_start = 1'b1;
        end
        while (!finished && cyc < 600) begin
            @(negedge CLK);
            cyc++;
            frame_start  = 1'b0;
            abort        = 1'b0;
            pix_ack      = 1'b0;
            pg_ready     = 1'b0;
            pg_iteration = $urandom;
            if (busy && busy_cyc < 0) busy_cyc = cyc;
            if (k_mid_fs == cyc) frame_start = 1'b1;
            if (pg_start) begin
                check("pg_start_while_write_pending", 64'(writing), 0);
                check("pg_xy", {pg_x, pg_y}, {12'(start_idx % W), 12'(start_idx / W)});
                r_starts++;
                waiting     = 1;
                ready_given = 0;
                wcnt        = 0;
                pg_ready    = k_stale;
                start_idx++;
            end else if (waiting && !pix_valid && start_idx > 0) begin
                wcnt++;
                if (k_rst_pix == start_idx - 1 && wcnt == 2) begin
                    RST = 1'b1;
                    #1;
                    check("rst_async_outs", 64'(outs0), 0);
                    check("rst_async_data", 64'(pix_data), 0);
                    #1 RST = 1'b0;
                    finished = 1;
                end else if (wcnt >= rd_arr[start_idx - 1]) begin
                    pg_ready     = 1'b1;
                    pg_iteration = it_arr[start_idx - 1];
                    ready_given  = 1;
                end
            end
            if (pix_valid && wr_idx < NPIX) begin
                if (!writing) begin
                    check("write_only_after_ready", 64'(ready_given), 1);
                    check("pix_write", {pix_x, pix_y, pix_data},
                          {12'(wr_idx % W), 12'(wr_idx / W), it_arr[wr_idx]});
                    writing = 1;
                    waiting = 0;
                    acnt    = 0;
                    held    = {pix_x, pix_y, pix_data};
                end else begin
                    check("pix_hold", {pix_x, pix_y, pix_data}, held);
                end
                acnt++;
                if (k_abort_pix == wr_idx) begin
                    abort    = 1'b1;
                    pix_ack  = 1'b1;
                    finished = 1;
                end else if (acnt >= ad_arr[wr_idx]) begin
                    pix_ack = 1'b1;
                    writing = 0;
                    wr_idx++;
                    r_writes++;
                end
            end
            if (frame_done) begin
                check("busy_low_at_done", 64'(busy), 0);
                check("all_written_at_done", 64'(wr_idx), NPIX);
                r_len       = cyc - busy_cyc;
                r_done_seen = 1;
                finished    = 1;
                if (k_fs_at_done) frame_start = 1'b1;
            end
        end
        if (!finished) check("frame_timeout", 0, 1);
    endtask

    initial begin
        vec_t vecs [4];
        int   cnt_start, cnt_done, exp_len;
        vecs[0] = '{rd: 1, ad: 1, exp_len: 24, exp_writes: 8};
        vecs[1] = '{rd: 2, ad: 1, exp_len: 32, exp_writes: 8};
        vecs[2] = '{rd: 1, ad: 3, exp_len: 40, exp_writes: 8};
        vecs[3] = '{rd: 4, ad: 2, exp_len: 56, exp_writes: 8};

        RST = 1'b0; frame_start = 0; abort = 0; pg_ready = 0; pg_iteration = '0; pix_ack = 0;
        s_frame_start = 0; s_abort = 0; s_pg_ready = 0; s_pg_iteration = '0; s_pix_ack = 0;
        #2 RST = 1'b1;
        #2;
        check("reset_outs", 64'(outs0), 0);
        check("reset_data", 64'(pix_data), 0);
        check("reset_outs_1x1", {s_busy, s_frame_done, s_pg_start, s_pix_valid, s_pg_x, s_pg_y, s_pix_x}, 0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;

        // Single-pixel grid: START, WAIT, WRITE, then frame_done.
        @(negedge CLK); s_frame_start = 1'b1;
        @(negedge CLK); s_frame_start = 1'b0;
        check("1x1_start", {s_pg_start, s_busy, s_pg_x, s_pg_y}, {2'b11, 24'd0});
        @(negedge CLK);
        check("1x1_no_early_write", 64'(s_pix_valid), 0);
        s_pg_ready = 1'b1; s_pg_iteration = 32'd99;
        @(negedge CLK); s_pg_ready = 1'b0;
        check("1x1_write", {s_pix_valid, s_pix_x, s_pix_y, s_pix_data}, {1'b1, 24'd0, 32'd99});
        s_pix_ack = 1'b1;
        @(negedge CLK); s_pix_ack = 1'b0;
        check("1x1_done", {s_frame_done, s_busy, s_pix_valid, s_pg_start}, 4'b1000);
        @(negedge CLK);
        check("1x1_done_one_cycle", {s_frame_done, s_busy}, 0);

        // Table of fixed generator/writer timings.
        foreach (vecs[i]) begin
            fill(vecs[i].rd, vecs[i].ad);
            run_frame();
            check("tbl_len", 64'(r_len), 64'(vecs[i].exp_len));
            check("tbl_starts", 64'(r_starts), 64'(vecs[i].exp_writes));
            check("tbl_writes", 64'(r_writes), 64'(vecs[i].exp_writes));
        end

        // Stale ready through START, then low for five WAIT cycles, then ready with 7.
        fill(1, 1);
        rd_arr[0] = 6; it_arr[0] = 32'd7;
        k_stale = 1;
        run_frame();
        k_stale = 0;
        check("stale_len", 64'(r_len), 24 + 5);
        check("stale_done", 64'(r_done_seen), 1);

        // Ack withheld for ten WRITE cycles at pixel (3,0).
        fill(1, 1);
        ad_arr[3] = 11;
        run_frame();
        check("ackhold_len", 64'(r_len), 24 + 10);
        check("ackhold_starts", 64'(r_starts), 8);

        // frame_start mid-frame (ignored) and in the frame_done cycle (accepted).
        fill(1, 1);
        k_mid_fs = 7; k_fs_at_done = 1;
        run_frame();
        k_mid_fs = -1; k_fs_at_done = 0;
        check("midfs_len", 64'(r_len), 24);
        check("midfs_starts", 64'(r_starts), 8);
        k_skip_start = 1;
        run_frame();
        k_skip_start = 0;
        check("chained_len", 64'(r_len), 24);
        check("chained_writes", 64'(r_writes), 8);

        // Abort together with ack while writing pixel (2,0).
        fill(1, 2);
        k_abort_pix = 2;
        run_frame();
        k_abort_pix = -1;
        check("abort_writes", 64'(r_writes), 2);
        @(negedge CLK);
        abort = 1'b0; pix_ack = 1'b0;
        check("abort_idle", {busy, pix_valid, pg_start, frame_done}, 0);
        cnt_start = 0; cnt_done = 0;
        repeat (8) begin
            @(negedge CLK);
            cnt_start += int'(pg_start);
            cnt_done  += int'(frame_done);
        end
        check("abort_no_start", 64'(cnt_start), 0);
        check("abort_no_done", 64'(cnt_done), 0);

        // Asynchronous reset in the second WAIT cycle of pixel (1,0), then a clean frame from (0,0).
        fill(1, 1);
        rd_arr[1] = 4;
        k_rst_pix = 1;
        run_frame();
        k_rst_pix = -1;
        check("rst_no_done", 64'(r_done_seen), 0);
        fill(1, 1);
        run_frame();
        check("after_rst_len", 64'(r_len), 24);

        // Random generator latencies, ack delays, iteration values and stale ready.
        for (int f = 0; f < 6; f++) begin
            for (int k = 0; k < NPIX; k++) begin
                rd_arr[k] = int'($urandom_range(1, 4));
                ad_arr[k] = int'($urandom_range(1, 4));
                it_arr[k] = $urandom;
            end
            k_stale = 1'($urandom_range(0, 1));
            exp_len = model_len();
            run_frame();
            check("rnd_len", 64'(r_len), 64'(exp_len));
            check("rnd_writes", 64'(r_writes), NPIX);
        end
        k_stale = 0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/point_dispatcher.md
Name: point_dispatcher

Overview:
- Frame-level driver for the Mandelbrot point generator.
- Scans the pixel grid in raster order and issues one start pulse per pixel with that pixel's (x, y).
- Waits for the generator's combinational ready, captures its iteration count, and presents it as a pixel write to the framebuffer writer over a valid/ack handshake.
- Sits between the frame controller (frame_start/frame_done) and a single point generator instance.

Parameters:
- WIDTH, 640, pixels per line; legal range 1..4096.
- HEIGHT, 480, lines per frame; legal range 1..4096.
- HBI, 32, iteration count width; must match the generator.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous reset, active-high.
- frame_start  in  1  one-cycle request to render a frame.
- abort  in  1  cancel the frame in progress.
- busy  out  1  high from frame acceptance until return to IDLE.
- frame_done  out  1  one-cycle pulse after the last pixel is acked.
- pg_start  out  1  start strobe to the generator.
- pg_x  out  12  pixel x to the generator.
- pg_y  out  12  pixel y to the generator.
- pg_ready  in  1  generator ready (combinational on its side).
- pg_iteration  in  HBI  generator iteration count.
- pix_valid  out  1  pixel write request.
- pix_x  out  12  write x.
- pix_y  out  12  write y.
- pix_data  out  HBI  write data (iteration count).
- pix_ack  in  1  write accepted.

Behaviour:
- Reset (async, RST=1):
  - State IDLE.
  - All outputs 0, counters x=y=0.
- All outputs are registered. pg_x/pg_y are driven from the x/y counters and are held stable for the whole pixel.
- States:
  - IDLE: frame_start=1 -> clear x,y; busy=1; go to START. All other inputs ignored.
  - START: pg_start=1 for exactly this one cycle -> WAIT.
  - WAIT: pg_ready is sampled starting with the first WAIT cycle. pg_ready is not trusted in the START cycle (stale from the previous point). On pg_ready=1, latch pg_iteration into pix_data and the current x,y into pix_x/pix_y; pix_valid=1 -> WRITE. Otherwise stay in WAIT. There is no timeout; the generator bounds the wait via max_iterations.
  - WRITE: hold pix_valid, pix_x, pix_y and pix_data unchanged until pix_ack=1. On the ack cycle:
    - pix_valid drops the next cycle.
    - If x<WIDTH-1: x++ and go to START.
    - Else if y<HEIGHT-1: x=0, y++ and go to START.
    - Else go to DONE.
  - DONE: frame_done=1 for one cycle, busy=0, -> IDLE.
- Per-pixel latency with pg_ready seen in the first WAIT cycle and immediate ack: 3 cycles (START, WAIT, WRITE). Pixels are not overlapped.
- frame_start while busy=1 is ignored, never queued.
- frame_start in the same cycle frame_done is high: state is already IDLE, so the new frame is accepted.
- abort (any non-IDLE state):
  - Next state IDLE; pg_start, pix_valid and busy forced to 0.
  - No frame_done is issued.
  - An in-flight write is dropped even if pix_ack arrives in the same cycle; abort has priority over pix_ack.
- RST mid-frame: immediate return to reset values; the next frame restarts at (0,0).
- Counters are 12 bits wide. WIDTH=1 and HEIGHT=1 must work (single pixel, then DONE).
- pix_ack outside WRITE is ignored.

Test Plan:
- WIDTH=4, HEIGHT=2; model generator ready 1 cycle after start with iteration=x+10*y; ack always 1 -> 8 writes in order (0,0)=0 … (3,1)=13; frame_done exactly 24 cycles after the frame_start acceptance cycle; exactly 8 pg_start pulses.
- Generator holds ready=1 stale through the START cycle, then 0 for 5 cycles, then 1 with iteration=7 -> pix_data=7; no write issued early.
- pix_ack held low for 10 cycles in WRITE -> pix_valid/pix_x/pix_y/pix_data stable for all 10 cycles; the next pg_start comes only after the ack.
- frame_start pulsed mid-frame and again in the frame_done cycle -> first ignored, second starts a new frame at (0,0).
- abort asserted in WRITE together with pix_ack at pixel (2,0) -> IDLE next cycle, no frame_done, no further pg_start.
- RST asserted asynchronously mid-WAIT -> all outputs 0 immediately; the following frame begins at (0,0).
